// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : program_loader
//  Description : Receives a length-prefixed big-endian byte stream, buffers
//                the 32-bit words, holds the CPU in reset while receiving,
//                bursts the words into instruction memory on back-to-back
//                cycles, flushes the CPU with a short reset, then releases it.
//  Revision    : 1.0 - initial release
// ============================================================================
module program_loader #(
    parameter int DEPTH        = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    input  logic        reload,
    output logic        cpu_reset,
    output logic        LoadInstructions,
    output logic [31:0] Instruction,
    output logic        load_done,
    output logic        load_error,
    output logic [15:0] words_loaded
);

    localparam int          AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [15:0] DEPTH_W    = 16'(DEPTH);
    localparam logic [15:0] FLUSH_LAST = 16'(FLUSH_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR_HI = 3'd1,
        ST_HDR_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_BURST  = 3'd4,
        ST_FLUSH  = 3'd5,
        ST_RUN    = 3'd6,
        ST_ERROR  = 3'd7
    } state_t;

    state_t         state;
    logic [7:0]     hdr_hi;
    logic [23:0]    shift;
    logic [1:0]     byte_cnt;
    logic [AW-1:0]  wr_idx;
    logic [AW-1:0]  rd_idx;
    logic [15:0]    remain;
    logic [15:0]    flush_cnt;
    logic [31:0]    mem [DEPTH];

    logic           xfer;
    logic [15:0]    hdr_n;
    logic [31:0]    word_in;
    logic           word_wr;
    logic           last_word;

    assign xfer      = byte_valid & byte_ready;
    assign hdr_n     = {hdr_hi, byte_data};
    assign word_in   = {shift, byte_data};
    assign word_wr   = (state == ST_DATA) && xfer && (byte_cnt == 2'd3);
    // N has been range-checked, so N-1 cannot underflow while in DATA
    assign last_word = ({{(16-AW){1'b0}}, wr_idx} == (words_loaded - 16'd1));

    // Word buffer: written when the fourth byte of a word arrives
    always_ff @(posedge clk) begin
        if (word_wr) begin
            mem[wr_idx] <= word_in;
        end
    end

    // Control FSM with all outputs registered
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state            <= ST_IDLE;
            hdr_hi           <= 8'd0;
            shift            <= 24'd0;
            byte_cnt         <= 2'd0;
            wr_idx           <= '0;
            rd_idx           <= '0;
            remain           <= 16'd0;
            flush_cnt        <= 16'd0;
            byte_ready       <= 1'b0;
            cpu_reset        <= 1'b1;
            LoadInstructions <= 1'b0;
            Instruction      <= 32'd0;
            load_done        <= 1'b0;
            load_error       <= 1'b0;
            words_loaded     <= 16'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state      <= ST_HDR_HI;
                    byte_ready <= 1'b1;
                end
                ST_HDR_HI: begin
                    if (xfer) begin
                        hdr_hi <= byte_data;
                        state  <= ST_HDR_LO;
                    end
                end
                ST_HDR_LO: begin
                    if (xfer) begin
                        if ((hdr_n == 16'd0) || (hdr_n > DEPTH_W)) begin
                            state      <= ST_ERROR;
                            byte_ready <= 1'b0;
                            load_error <= 1'b1;
                        end else begin
                            state        <= ST_DATA;
                            words_loaded <= hdr_n;
                            wr_idx       <= '0;
                            byte_cnt     <= 2'd0;
                        end
                    end
                end
                ST_DATA: begin
                    if (xfer) begin
                        if (byte_cnt == 2'd3) begin
                            byte_cnt <= 2'd0;
                            wr_idx   <= wr_idx + 1'b1;
                            if (last_word) begin
                                state            <= ST_BURST;
                                byte_ready       <= 1'b0;
                                cpu_reset        <= 1'b0;
                                LoadInstructions <= 1'b1;
                                // a one-word program is still being written: bypass it
                                Instruction      <= (wr_idx == '0) ? word_in : mem[0];
                                rd_idx           <= AW'(1);
                                remain           <= words_loaded - 16'd1;
                            end
                        end else begin
                            shift    <= {shift[15:0], byte_data};
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
                end
                ST_BURST: begin
                    if (remain == 16'd0) begin
                        state            <= ST_FLUSH;
                        LoadInstructions <= 1'b0;
                        Instruction      <= 32'd0;
                        cpu_reset        <= 1'b1;
                        flush_cnt        <= FLUSH_LAST;
                    end else begin
                        Instruction <= mem[rd_idx];
                        rd_idx      <= rd_idx + 1'b1;
                        remain      <= remain - 16'd1;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt == 16'd0) begin
                        state     <= ST_RUN;
                        cpu_reset <= 1'b0;
                        load_done <= 1'b1;
                    end else begin
                        flush_cnt <= flush_cnt - 16'd1;
                    end
                end
                ST_RUN, ST_ERROR: begin
                    if (reload) begin
                        state      <= ST_HDR_HI;
                        cpu_reset  <= 1'b1;
                        byte_ready <= 1'b1;
                        load_done  <= 1'b0;
                        load_error <= 1'b0;
                        wr_idx     <= '0;
                        byte_cnt   <= 2'd0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
